// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences interrupt/ecall/ebreak/mret entry and exit around the MEM-stage CSR unit,
// flushing younger stages and redirecting fetch to the CSR-supplied target.
module trap_ctrl #(
    parameter int ADDR_W  = 64,
    parameter int HOLDOFF = 1,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_ctrl_csr_trap_i,
    input  logic [ADDR_W-1:0] trap_ctrl_csr_nxt_pc_i,
    input  logic              trap_ctrl_mem_valid_i,
    input  logic              trap_ctrl_mem_busy_i,
    input  logic              trap_ctrl_mem_trap_i,
    input  logic              trap_ctrl_mem_mret_i,
    input  logic              trap_ctrl_if_ready_i,
    output logic              trap_ctrl_intp_en_o,
    output logic              trap_ctrl_flush_o,
    output logic              trap_ctrl_redirect_valid_o,
    output logic [ADDR_W-1:0] trap_ctrl_redirect_pc_o,
    output logic              trap_ctrl_busy_o,
    output logic [CNT_W-1:0]  trap_ctrl_intp_cnt_o
);
    typedef enum logic [1:0] {IDLE, ARMED, REDIR} state_t;
    localparam int HW = HOLDOFF > 0 ? $clog2(HOLDOFF + 1) : 1;
    state_t         state;
    logic [HW-1:0]  holdoff_cnt;
    logic           was_mret;
    logic           commit;
    logic           hold_z;
    logic           sync_trap;
    always_comb begin
        commit              = trap_ctrl_mem_valid_i & ~trap_ctrl_mem_busy_i;
        hold_z              = holdoff_cnt == '0;
        // Gated by rst so the Mealy pulses also drop the instant reset asserts.
        trap_ctrl_intp_en_o = rst & (state == ARMED) & trap_ctrl_csr_trap_i & commit & hold_z;
        sync_trap           = rst & (state != REDIR) & commit
                              & (trap_ctrl_mem_trap_i | trap_ctrl_mem_mret_i) & ~trap_ctrl_intp_en_o;
        trap_ctrl_flush_o   = trap_ctrl_intp_en_o | sync_trap;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                      <= IDLE;
            holdoff_cnt                <= '0;
            was_mret                   <= 1'b0;
            trap_ctrl_redirect_valid_o <= 1'b0;
            trap_ctrl_redirect_pc_o    <= '0;
            trap_ctrl_busy_o           <= 1'b0;
            trap_ctrl_intp_cnt_o       <= '0;
        end else if (state == REDIR) begin
            if (trap_ctrl_if_ready_i) begin
                state                      <= IDLE;
                trap_ctrl_redirect_valid_o <= 1'b0;
                trap_ctrl_busy_o           <= 1'b0;
                if (was_mret) holdoff_cnt <= HW'(HOLDOFF);
            end
        end else begin
            if (commit && !hold_z) holdoff_cnt <= holdoff_cnt - HW'(1);
            if (trap_ctrl_flush_o) begin
                state                      <= REDIR;
                was_mret                   <= sync_trap & trap_ctrl_mem_mret_i;
                trap_ctrl_redirect_valid_o <= 1'b1;
                trap_ctrl_redirect_pc_o    <= trap_ctrl_csr_nxt_pc_i;
                trap_ctrl_busy_o           <= 1'b1;
                if (trap_ctrl_intp_en_o) trap_ctrl_intp_cnt_o <= trap_ctrl_intp_cnt_o + CNT_W'(1);
            end else if (state == ARMED) begin
                state <= trap_ctrl_csr_trap_i ? ARMED : IDLE;
            end else begin
                state <= (trap_ctrl_csr_trap_i && hold_z) ? ARMED : IDLE;
            end
        end
    end
endmodule
